// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch front end for the RV32 core. Owns the program counter,
// drives the single-port instruction-memory request interface and presents
// fetched words to decode through an output register backed by a one-entry
// skid buffer. JALs are recognised on the returning word and steer the next
// fetch immediately. Redirects from execute win over everything and flush
// whatever is in flight.
//
// Optional feature: define FETCH_JAL_CNT_EN to build the 32-bit counter of
// accepted JAL words on jal_count. Without it jal_count is tied to zero.

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] jal_count
);

    // Canonical NOP (addi x0, x0, 0) shown to decode before anything is fetched.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL   = 7'b1101111;

    // START : one idle cycle after reset before the first request.
    // FETCH : request outstanding at pc.
    // DRAIN : a redirect arrived while a request was pending; the old request
    //         must finish with its address stable and its data is thrown away.
    // FULL  : skid holds a word because decode stalled with the output full.
    typedef enum logic [1:0] {
        START,
        FETCH,
        DRAIN,
        FULL
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] drain_addr;
    logic [31:0] drain_addr_nx;

    logic        if_valid_nx;
    logic [31:0] if_pc_nx;
    logic [31:0] if_instr_nx;

    // The skid entry is occupied exactly when the FSM sits in FULL, so only
    // its payload needs storage.
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc_nx;
    logic [31:0] skid_instr_nx;

    logic        is_jal;
    logic [31:0] imm_j;
    logic [31:0] redirect_pc;
    logic        word_accept;

    // Decode the returning word and the redirect target independent of state.
    always_comb begin
        is_jal      = (imem_rdata[6:0] == OPC_JAL);
        imm_j       = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                       imem_rdata[20], imem_rdata[30:21], 1'b0};
        redirect_pc = ex_target & 32'hFFFF_FFFC;
        word_accept = (state == FETCH) && imem_ack && !ex_redirect;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, memory request and datapath updates; redirect handling is
    // applied last so that it overrides stall, ack and JAL steering.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        drain_addr_nx = drain_addr;
        if_valid_nx   = if_valid;
        if_pc_nx      = if_pc;
        if_instr_nx   = if_instr;
        skid_pc_nx    = skid_pc;
        skid_instr_nx = skid_instr;
        imem_req      = 1'b0;
        imem_addr     = pc;

        if (!stall) begin
            if_valid_nx = 1'b0;
        end

        case (state)
            START: begin
                state_nx = FETCH;
            end

            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (word_accept) begin
                    if (!if_valid || !stall) begin
                        if_valid_nx = 1'b1;
                        if_pc_nx    = pc;
                        if_instr_nx = imem_rdata;
                    end else begin
                        skid_pc_nx    = pc;
                        skid_instr_nx = imem_rdata;
                        state_nx      = FULL;
                    end
                    if (is_jal) begin
                        pc_nx = pc + imm_j;
                    end else begin
                        pc_nx = pc + 32'd4;
                    end
                end
            end

            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ack) begin
                    state_nx = FETCH;
                end
            end

            FULL: begin
                if (!stall) begin
                    if_valid_nx = 1'b1;
                    if_pc_nx    = skid_pc;
                    if_instr_nx = skid_instr;
                    state_nx    = FETCH;
                end
            end

            default: begin
                state_nx = START;
            end
        endcase

        if (ex_redirect) begin
            pc_nx       = redirect_pc;
            if_valid_nx = 1'b0;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        state_nx = FETCH;
                    end else begin
                        state_nx      = DRAIN;
                        drain_addr_nx = pc;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_nx = FETCH;
                    end else begin
                        state_nx = DRAIN;
                    end
                end
                default: begin
                    state_nx = FETCH;
                end
            endcase
        end
    end

    // Program counter, drain address, output register and skid payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0000_0000;
            if_instr   <= NOP_INSTR;
            skid_pc    <= 32'h0000_0000;
            skid_instr <= NOP_INSTR;
        end else begin
            pc         <= pc_nx;
            drain_addr <= drain_addr_nx;
            if_valid   <= if_valid_nx;
            if_pc      <= if_pc_nx;
            if_instr   <= if_instr_nx;
            skid_pc    <= skid_pc_nx;
            skid_instr <= skid_instr_nx;
        end
    end

`ifdef FETCH_JAL_CNT_EN
    // Count JAL words that were actually accepted; discarded words never count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jal_count <= 32'h0000_0000;
        end else if (word_accept && is_jal) begin
            jal_count <= jal_count + 32'd1;
        end
    end
`else
    assign jal_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Cycle table for reset, sequential fetch, JAL steering, redirects and the
// stall/skid path, followed by hand-written sequences for a redirect during
// memory wait states and a reset in the middle of a request. Instructions
// handed to decode are checked against a scoreboard queue.

module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

`ifdef FETCH_JAL_CNT_EN
    localparam bit JAL_CNT_EN = 1'b1;
`else
    localparam bit JAL_CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] jal_count;

    int wait_states;
    int wait_cnt;
    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_item_t;

    sb_item_t sb_queue[$];
    sb_item_t sb_head;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        exp_req;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_jal;
    } vec_t;

    vec_t vecs[23];

    fetch_sequencer #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .ex_redirect(ex_redirect),
        .ex_target  (ex_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .jal_count  (jal_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: two JALs, every other word a non-JAL
    // OP-IMM encoding that is unique per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h0080_006F;
        if (a == 32'h0000_0300) return 32'hFFDF_F06F;
        return {a[24:0], 7'b0010011};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && (wait_cnt >= wait_states);

    // Memory wait-state counter: cycles the current request has been pending.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (!imem_req || imem_ack) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [31:0] pc);
        sb_item_t item;
        item.pc    = pc;
        item.instr = mem_word(pc);
        sb_queue.push_back(item);
    endtask

    task automatic applyStimulus(input vec_t v);
        stall       = v.stall;
        ex_redirect = v.redir;
        ex_target   = v.target;
        if (v.exp_valid && !v.stall) begin
            pushExpected(v.exp_pc);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] tg,
                                input logic rq, input logic ca, input logic [31:0] ad,
                                input logic vl, input logic [31:0] pc, input logic [31:0] jc);
        vec_t v;
        v.stall     = st;
        v.redir     = rd;
        v.target    = tg;
        v.exp_req   = rq;
        v.chk_addr  = ca;
        v.exp_addr  = ad;
        v.exp_valid = vl;
        v.exp_pc    = pc;
        v.exp_jal   = jc;
        return v;
    endfunction

    // Whenever decode consumes a word, it must be the next one the bench expects.
    always @(negedge clk) begin
        #2;
        if (!rst && if_valid && !stall) begin
            if (sb_queue.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL sb_unexpected: got if_pc 0x%08h, expected no word", if_pc);
            end else begin
                sb_head = sb_queue.pop_front();
                checkOutput("sb_if_pc", if_pc, sb_head.pc);
                checkOutput("sb_if_instr", if_instr, sb_head.instr);
            end
        end
    end

    // Main sequence.
    initial begin
        vec_t v;
        int   n;

        n_checks    = 0;
        n_fail      = 0;
        wait_states = 0;
        rst         = 1'b0;
        stall       = 1'b0;
        ex_redirect = 1'b0;
        ex_target   = 32'h0;

        vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'd0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 32'd0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 32'd0);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h108, 32'd0);
        vecs[5]  = mk(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C, 32'd0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'd0);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200, 32'd1);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 1'b1, 32'h208, 32'd1);
        vecs[9]  = mk(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h210, 1'b1, 32'h20C, 32'd1);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   32'd1);
        vecs[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h2FC, 1'b1, 32'h300, 32'd2);
        vecs[12] = mk(1'b0, 1'b1, 32'h803, 1'b1, 1'b1, 32'h300, 1'b1, 32'h2FC, 32'd2);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h800, 1'b0, 32'h0,   32'd2);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h804, 1'b1, 32'h800, 32'd2);
        vecs[15] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h808, 1'b1, 32'h804, 32'd2);
        vecs[16] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h804, 32'd2);
        vecs[17] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h804, 32'd2);
        vecs[18] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h804, 32'd2);
        vecs[19] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h804, 32'd2);
        vecs[20] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h80C, 1'b1, 32'h808, 32'd2);
        vecs[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h810, 1'b1, 32'h80C, 32'd2);
        vecs[22] = mk(1'b0, 1'b1, 32'h10,  1'b1, 1'b1, 32'h814, 1'b1, 32'h810, 32'd2);

        #1 rst = 1'b1;
        #2;
        $display("[TB] checking reset state");
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("rst_imem_addr", imem_addr, RST_PC);
        checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0000_0013);
        checkOutput("rst_jal_count", jal_count, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        $display("[TB] running cycle table");
        for (int i = 0; i < 23; i++) begin
            v = vecs[i];
            applyStimulus(v);
            #1;
            checkOutput($sformatf("row%0d_imem_req", i), 32'(imem_req), 32'(v.exp_req));
            if (v.chk_addr) begin
                checkOutput($sformatf("row%0d_imem_addr", i), imem_addr, v.exp_addr);
            end
            checkOutput($sformatf("row%0d_if_valid", i), 32'(if_valid), 32'(v.exp_valid));
            if (v.exp_valid) begin
                checkOutput($sformatf("row%0d_if_pc", i), if_pc, v.exp_pc);
            end
            checkOutput($sformatf("row%0d_jal_count", i), jal_count,
                        JAL_CNT_EN ? v.exp_jal : 32'h0);
            @(negedge clk);
        end

        // Redirect to 0x400 one cycle after a slow request to 0x10 is issued.
        $display("[TB] redirect during wait states");
        stall       = 1'b0;
        ex_redirect = 1'b0;
        wait_states = 3;
        #1;
        checkOutput("drain_req_c0", 32'(imem_req), 32'h1);
        checkOutput("drain_addr_c0", imem_addr, 32'h10);
        checkOutput("drain_valid_c0", 32'(if_valid), 32'h0);
        @(negedge clk);
        ex_redirect = 1'b1;
        ex_target   = 32'h400;
        #1;
        checkOutput("drain_addr_c1", imem_addr, 32'h10);
        checkOutput("drain_valid_c1", 32'(if_valid), 32'h0);
        @(negedge clk);
        ex_redirect = 1'b0;
        for (int c = 2; c < 4; c++) begin
            #1;
            checkOutput($sformatf("drain_req_c%0d", c), 32'(imem_req), 32'h1);
            checkOutput($sformatf("drain_addr_c%0d", c), imem_addr, 32'h10);
            checkOutput($sformatf("drain_valid_c%0d", c), 32'(if_valid), 32'h0);
            @(negedge clk);
        end
        #1;
        checkOutput("drain_req_c4", 32'(imem_req), 32'h1);
        checkOutput("drain_addr_c4", imem_addr, 32'h400);
        checkOutput("drain_valid_c4", 32'(if_valid), 32'h0);
        checkOutput("drain_jal_count", jal_count, JAL_CNT_EN ? 32'd2 : 32'h0);
        pushExpected(32'h400);
        n = 0;
        while (!if_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain_first_valid", 32'(if_valid), 32'h1);
        checkOutput("drain_first_pc", if_pc, 32'h400);

        // Reset while the request to 0x404 is waiting on memory.
        $display("[TB] reset during a pending request");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("midrst_imem_addr", imem_addr, RST_PC);
        checkOutput("midrst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("midrst_if_instr", if_instr, 32'h0000_0013);
        checkOutput("midrst_jal_count", jal_count, 32'h0);
        @(negedge clk);
        rst         = 1'b0;
        wait_states = 0;
        #1;
        checkOutput("restart_start_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("restart_req", 32'(imem_req), 32'h1);
        checkOutput("restart_addr0", imem_addr, RST_PC);
        checkOutput("restart_valid0", 32'(if_valid), 32'h0);
        @(negedge clk);
        pushExpected(RST_PC);
        #1;
        checkOutput("restart_addr1", imem_addr, RST_PC + 32'd4);
        checkOutput("restart_valid1", 32'(if_valid), 32'h1);
        checkOutput("restart_pc1", if_pc, RST_PC);
        @(negedge clk);
        stall = 1'b1;
        #1;
        checkOutput("restart_hold_pc", if_pc, RST_PC + 32'd4);
        @(negedge clk);
        @(negedge clk);
        #3;
        checkOutput("sb_empty", 32'(sb_queue.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
